uart_tx_framed: RTL and testbench
=================================

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 Parameter CLOCK_SPEED, default 50_000_000, is the input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, is the line rate in bits/s.
REQ-003 Parameter DATA_BITS, default 8, range 5..9, is the number of payload bits per frame.
REQ-004 Parameter PARITY, default 0, selects parity: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, range 1..2, is the number of stop bits.
REQ-006 Parameter FIFO_DEPTH, default 4, power of two, minimum 2, is the number of entries in the transmit FIFO.
REQ-007 Port clk, input, 1, is the single clock; all logic is on its rising edge.
REQ-008 Port rst, input, 1, is the reset: synchronous and active-high.
REQ-009 Port data, input, DATA_BITS, is the payload word to enqueue.
REQ-010 Port send, input, 1, is valid: a word is offered this cycle.
REQ-011 Port ready, output, 1, is high when the FIFO can accept a word.
REQ-012 Port tx, output, 1, is the serial line, registered, idle high.
REQ-013 Port tx_done, output, 1, is a one-cycle pulse when a frame's final stop bit completes.
REQ-014 Port busy, output, 1, is high whenever the state is not IDLE.
REQ-015 Port fifo_count, output, $clog2(FIFO_DEPTH)+1, is the current FIFO occupancy.

Function
REQ-016 BAUD_WIDTH SHALL be CLOCK_SPEED/BAUD_RATE (integer division); elaboration SHALL fail if BAUD_WIDTH < 2 or any parameter is out of range.
REQ-017 Every line bit SHALL last exactly BAUD_WIDTH clk cycles; the baud counter SHALL reload to 0 at each bit boundary.
REQ-018 The frame SHALL be: one start bit (0), DATA_BITS data bits LSB first, one parity bit if PARITY != 0, then STOP_BITS stop bits (1).
REQ-019 Parity SHALL be the XOR of the data bits for even parity and its inverse for odd parity.
REQ-020 The state machine SHALL have the states IDLE, START, DATA, PARITY and STOP.
  - IDLE->START when the FIFO is non-empty.
  - START->DATA after BAUD_WIDTH cycles.
  - DATA->PARITY, or DATA->STOP when PARITY=0, after DATA_BITS bit periods.
  - PARITY->STOP after one bit period.
  - STOP->START, or STOP->IDLE when the FIFO is empty, after STOP_BITS bit periods.
REQ-021 On the IDLE->START edge, and on the STOP->START edge, the FIFO head SHALL be popped into the shift register in the same cycle; the captured word SHALL NOT change mid-frame.
REQ-022 tx SHALL be low in the cycle after the edge that enters START; back-to-back frames SHALL have zero idle cycles between the last stop bit and the next start bit.
REQ-023 ready SHALL equal (fifo_count < FIFO_DEPTH); a push occurs iff send && ready.
REQ-024 A word pushed into an empty FIFO while IDLE SHALL be popped on the next edge, so tx falls 2 cycles after the push edge.
REQ-025 Push and pop in the same cycle SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-026 send while full SHALL be ignored, with no overwrite and no count change.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 tx_done SHALL pulse in the cycle after the final stop bit ends, whether the next state is IDLE or START.
REQ-029 busy SHALL be low only in IDLE.

Reset
REQ-030 While rst is high at a clk edge: state := IDLE, tx := 1, tx_done := 0, busy := 0, fifo_count := 0, FIFO pointers := 0, baud and bit counters := 0.
REQ-031 Reset mid-frame SHALL abandon the frame, with tx high from the first post-reset cycle, and SHALL discard all FIFO contents.
REQ-032 ready SHALL be high in the first cycle after reset is released.

Verification
REQ-033 Single frame: CLOCK_SPEED=400, BAUD_RATE=100 (BAUD_WIDTH=4), 8N1, push 0xA5 -> tx is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; tx_done pulses once, 40 cycles after tx falls.
REQ-034 Parity: DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x03 -> data bits 1100000, parity 1, two stop bits; frame length 11x BAUD_WIDTH.
REQ-035 Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames with no idle gap, in order; exactly three tx_done pulses.
REQ-036 Full: FIFO_DEPTH=4, hold send during a frame -> ready drops when fifo_count=4; extra words are dropped; 5 frames are transmitted (1 in flight + 4 queued).
REQ-037 Reset mid-frame: assert rst during data bit 3 -> tx=1 the next cycle; fifo_count=0; no tx_done; a new push afterwards transmits correctly.
REQ-038 Simultaneous push and pop: push on the STOP->START edge with fifo_count=2 -> fifo_count stays 2 and order is preserved.

Source files
------------

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: a small FIFO feeds a start/data/parity/stop framer.
// The line and the done pulse are registered one cycle behind the state machine.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to hold a word
// S_START  | driving the start bit (0)
// S_DATA   | shifting payload bits out, LSB first
// S_PARITY | driving the even/odd parity bit
// S_STOP   | driving stop bit(s); pops the next word on the last one
module uart_tx_framed #(
   parameter int CLOCK_SPEED = 50_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          send,
   output logic                          ready,
   output logic                          tx,
   output logic                          tx_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int BCW        = $clog2(BAUD_WIDTH);

   if (BAUD_WIDTH < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_framed: parameter out of range");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                 state;
   logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]          wptr;
   logic [AW-1:0]          rptr;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_bit;
   logic [BCW-1:0]         baud_cnt;
   logic [3:0]             bit_cnt;
   logic                   done_q;
   logic                   line;
   logic                   push;
   logic                   pop;
   logic                   non_empty;
   logic                   bit_end;
   logic [DATA_BITS-1:0]   head;

   assign ready     = fifo_count < (AW + 1)'(FIFO_DEPTH);
   assign push      = send && ready;
   assign non_empty = fifo_count != '0;
   assign bit_end   = baud_cnt == BCW'(BAUD_WIDTH - 1);
   assign head      = mem[rptr];
   // The next word is taken either from idle or straight off the last stop bit, so frames abut.
   assign pop       = non_empty && ((state == S_IDLE) ||
                      (state == S_STOP && bit_end && bit_cnt == 4'(STOP_BITS - 1)));

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= data;
   end

   always_comb begin
      line = 1'b1;
      case (state)
         S_START:  line = 1'b0;
         S_DATA:   line = shreg[0];
         S_PARITY: line = par_bit;
         default:  line = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tx         <= 1'b1;
         tx_done    <= 1'b0;
         done_q     <= 1'b0;
         busy       <= 1'b0;
         fifo_count <= '0;
         wptr       <= '0;
         rptr       <= '0;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
      end else begin
         tx      <= line;
         tx_done <= done_q;
         done_q  <= 1'b0;

         if (push) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr    <= rptr + 1'b1;
            shreg   <= head;
            par_bit <= (^head) ^ 1'(PARITY == 2);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         case (state)
            S_IDLE: begin
               if (non_empty) begin
                  state    <= S_START;
                  busy     <= 1'b1;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
               end
            end
            S_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= S_DATA;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            S_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shreg    <= shreg >> 1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else bit_cnt <= bit_cnt + 1'b1;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            S_PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= S_STOP;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            S_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 4'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     done_q  <= 1'b1;
                     if (non_empty) state <= S_START;
                     else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else bit_cnt <= bit_cnt + 1'b1;
               end else baud_cnt <= baud_cnt + 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: an 8N1 instance and a 7O2 instance, both at four clocks per bit.
// Single frames come from a table; queueing, full FIFO and reset are hand-written sequences.
module tb_uart_tx_framed;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] data_a;
   logic       send_a, ready_a, tx_a, done_a, busy_a;
   logic [2:0] cnt_a;
   logic [6:0] data_b;
   logic       send_b, ready_b, tx_b, done_b, busy_b;
   logic [2:0] cnt_b;

   uart_tx_framed #(.CLOCK_SPEED(400), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .data(data_a), .send(send_a), .ready(ready_a),
      .tx(tx_a), .tx_done(done_a), .busy(busy_a), .fifo_count(cnt_a));

   uart_tx_framed #(.CLOCK_SPEED(400), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .data(data_b), .send(send_b), .ready(ready_b),
      .tx(tx_b), .tx_done(done_b), .busy(busy_b), .fifo_count(cnt_b));

   int checks = 0;
   int errors = 0;
   int done_cnt_a = 0;

   always @(posedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

   typedef struct {
      bit         sel;
      logic [8:0] word;
      int         nbits;
      logic [11:0] frame;
   } vec_t;

   vec_t tbl[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic cur_tx(input bit sel);
      return sel ? tx_b : tx_a;
   endfunction

   function automatic logic cur_done(input bit sel);
      return sel ? done_b : done_a;
   endfunction

   function automatic logic cur_busy(input bit sel);
      return sel ? busy_b : busy_a;
   endfunction

   task automatic drive(input bit sel, input logic [8:0] w, input logic s);
      if (sel) begin
         send_b = s;
         data_b = w[6:0];
      end else begin
         send_a = s;
         data_a = w[7:0];
      end
   endtask

   // Push one word into an idle instance and check every cycle of the resulting frame.
   task automatic run_vec(input vec_t v);
      int bad;
      int ndone;
      bad   = 0;
      ndone = 0;
      drive(v.sel, v.word, 1'b1);
      @(negedge clk);
      drive(v.sel, v.word, 1'b0);
      check("idle_after_push", int'(cur_tx(v.sel)), 1);
      @(negedge clk);
      check("tx_high_at_pop", int'(cur_tx(v.sel)), 1);
      check("busy_in_start", int'(cur_busy(v.sel)), 1);
      @(negedge clk);
      for (int k = 0; k < v.nbits * 4; k++) begin
         if (cur_tx(v.sel) !== v.frame[k / 4]) bad++;
         if (cur_done(v.sel) === 1'b1) ndone++;
         @(negedge clk);
      end
      check("frame_bits", bad, 0);
      check("done_early", ndone, 0);
      check("done_pulse", int'(cur_done(v.sel)), 1);
      @(negedge clk);
      check("done_one_cycle", int'(cur_done(v.sel)), 0);
      check("busy_after", int'(cur_busy(v.sel)), 0);
   endtask

   // Mid-bit sampler for instance A: waits for a start bit, returns the payload.
   task automatic recv_a(output logic [7:0] w, output bit ok);
      logic [9:0] bits;
      int i;
      i = 0;
      while (tx_a !== 1'b0 && i < 400) begin
         @(negedge clk);
         i++;
      end
      if (tx_a !== 1'b0) begin
         ok = 1'b0;
         w  = '0;
         return;
      end
      repeat (2) @(negedge clk);
      bits[0] = tx_a;
      for (int j = 1; j < 10; j++) begin
         repeat (4) @(negedge clk);
         bits[j] = tx_a;
      end
      @(negedge clk);
      ok = (bits[0] === 1'b0) && (bits[9] === 1'b1);
      w  = bits[8:1];
   endtask

   function automatic logic b2b_bit(input int k);
      logic [7:0] words [4];
      int b;
      words[0] = 8'h00;
      words[1] = 8'hFF;
      words[2] = 8'h55;
      words[3] = 8'h81;
      b = (k % 40) / 4;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return words[k / 40][b - 1];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w;
      bit ok;
      int snap;
      int bad;
      int dbad;

      tbl[0] = '{1'b0, 9'h0A5, 10, 12'h34A};
      tbl[1] = '{1'b0, 9'h000, 10, 12'h200};
      tbl[2] = '{1'b0, 9'h0FF, 10, 12'h3FE};
      tbl[3] = '{1'b0, 9'h03C, 10, 12'h278};
      tbl[4] = '{1'b1, 9'h003, 11, 12'h706};
      tbl[5] = '{1'b1, 9'h001, 11, 12'h602};

      rst    = 1'b1;
      send_a = 1'b0;
      data_a = '0;
      send_b = 1'b0;
      data_b = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", int'(tx_a), 1);
      check("rst_busy", int'(busy_a), 0);
      check("rst_done", int'(done_a), 0);
      check("rst_count", int'(cnt_a), 0);
      check("rst_tx_b", int'(tx_b), 1);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(ready_a), 1);
      check("ready_after_rst_b", int'(ready_b), 1);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Back-to-back: three consecutive pushes, then one push exactly on a STOP->START edge.
      repeat (2) @(negedge clk);
      snap = done_cnt_a;
      send_a = 1'b1;
      data_a = 8'h00;
      @(negedge clk);
      data_a = 8'hFF;
      @(negedge clk);
      data_a = 8'h55;
      @(negedge clk);
      send_a = 1'b0;
      check("b2b_count_after_pushes", int'(cnt_a), 2);
      bad  = 0;
      dbad = 0;
      for (int k = 0; k < 160; k++) begin
         if (k == 38) begin
            check("pushpop_count_before", int'(cnt_a), 2);
            send_a = 1'b1;
            data_a = 8'h81;
         end
         if (k == 39) begin
            check("pushpop_count_after", int'(cnt_a), 2);
            send_a = 1'b0;
         end
         if (tx_a !== b2b_bit(k)) bad++;
         if (done_a !== ((k > 0 && k % 40 == 0) ? 1'b1 : 1'b0)) dbad++;
         @(negedge clk);
      end
      check("b2b_stream", bad, 0);
      check("b2b_done_pattern", dbad, 0);
      check("b2b_last_done", int'(done_a), 1);
      @(negedge clk);
      check("b2b_done_total", done_cnt_a - snap, 4);
      check("b2b_empty", int'(cnt_a), 0);

      // Full FIFO: hold send for ten cycles; one word goes in flight, four queue, rest drop.
      repeat (4) @(negedge clk);
      snap = done_cnt_a;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send_a = 1'b1;
               data_a = 8'h10 + 8'(i);
               @(negedge clk);
               if (i == 5) begin
                  check("full_count", int'(cnt_a), 4);
                  check("full_ready", int'(ready_a), 0);
               end
            end
            send_a = 1'b0;
         end
         begin
            for (int f = 0; f < 5; f++) begin
               recv_a(w, ok);
               check("full_frame", ok ? int'(w) : -1, 'h10 + f);
            end
         end
      join
      bad = 0;
      repeat (100) begin
         if (tx_a !== 1'b1) bad++;
         @(negedge clk);
      end
      check("full_no_extra_frame", bad, 0);
      check("full_done_total", done_cnt_a - snap, 5);

      // Reset during data bit 3 with a second word still queued.
      send_a = 1'b1;
      data_a = 8'hA5;
      @(negedge clk);
      data_a = 8'h3C;
      @(negedge clk);
      send_a = 1'b0;
      @(negedge clk);
      repeat (17) @(negedge clk);
      check("pre_rst_count", int'(cnt_a), 1);
      check("pre_rst_bit3", int'(tx_a), 0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", int'(tx_a), 1);
      check("mid_rst_count", int'(cnt_a), 0);
      check("mid_rst_busy", int'(busy_a), 0);
      check("mid_rst_done", int'(done_a), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", int'(ready_a), 1);
      snap = done_cnt_a;
      bad  = 0;
      repeat (60) begin
         if (tx_a !== 1'b1) bad++;
         @(negedge clk);
      end
      check("post_rst_line_idle", bad, 0);
      check("post_rst_no_done", done_cnt_a - snap, 0);
      fork
         begin
            send_a = 1'b1;
            data_a = 8'h5A;
            @(negedge clk);
            send_a = 1'b0;
         end
         begin
            recv_a(w, ok);
            check("post_rst_frame", ok ? int'(w) : -1, 'h5A);
         end
      join
      repeat (4) @(negedge clk);
      check("post_rst_done_total", done_cnt_a - snap, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
